// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode constants, control encodings and the control-bundle records
// used by the decoder and the ID/EX/MEM/WB control pipeline.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
    result_src_t result_src;
    alu_op_t     alu_op;
  } ctrl_bundle_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_t result_src;
  } mem_ctrl_t;

  localparam ctrl_bundle_t CTRL_BUBBLE  = '0;
  localparam ctrl_bundle_t CTRL_ILLEGAL = '{illegal: 1'b1, result_src: RES_ALU,
                                            alu_op: ALUOP_ADD, default: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder: opcode -> control bundle and immediate format.
// With EXT_EN=0 the jump/upper-immediate opcodes fall through to illegal.
module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int EXT_EN = 1
) (
  input  logic [6:0]   op_i,
  output ctrl_bundle_t ctrl_o,
  output logic [2:0]   imm_src_o
);

  ctrl_bundle_t dec_ctrl;
  imm_src_t     dec_imm;
  logic         ext_on;

  assign ext_on = (EXT_EN != 0);

  // Opcode decode; every recognised opcode starts from an all-zero bundle.
  always_comb begin
    dec_ctrl = CTRL_ILLEGAL;
    dec_imm  = IMM_I;
    case (op_i)
      OP_LOAD: begin
        dec_ctrl            = CTRL_BUBBLE;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        dec_ctrl           = CTRL_BUBBLE;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_imm            = IMM_S;
      end
      OP_R: begin
        dec_ctrl           = CTRL_BUBBLE;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_I_ALU: begin
        dec_ctrl           = CTRL_BUBBLE;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        dec_ctrl        = CTRL_BUBBLE;
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALUOP_BRANCH;
        dec_imm         = IMM_B;
      end
      OP_JAL: begin
        if (ext_on) begin
          dec_ctrl            = CTRL_BUBBLE;
          dec_ctrl.reg_write  = 1'b1;
          dec_ctrl.jump       = 1'b1;
          dec_ctrl.result_src = RES_PC4;
          dec_imm             = IMM_J;
        end else begin
          dec_ctrl = CTRL_ILLEGAL;
        end
      end
      OP_JALR: begin
        if (ext_on) begin
          dec_ctrl            = CTRL_BUBBLE;
          dec_ctrl.reg_write  = 1'b1;
          dec_ctrl.alu_src    = 1'b1;
          dec_ctrl.jump       = 1'b1;
          dec_ctrl.jalr       = 1'b1;
          dec_ctrl.result_src = RES_PC4;
        end else begin
          dec_ctrl = CTRL_ILLEGAL;
        end
      end
      OP_LUI, OP_AUIPC: begin
        if (ext_on) begin
          dec_ctrl            = CTRL_BUBBLE;
          dec_ctrl.reg_write  = 1'b1;
          dec_ctrl.alu_src    = 1'b1;
          dec_ctrl.result_src = (op_i == OP_LUI) ? RES_IMM : RES_ALU;
          dec_imm             = IMM_U;
        end else begin
          dec_ctrl = CTRL_ILLEGAL;
        end
      end
      default: begin
        dec_ctrl = CTRL_ILLEGAL;
        dec_imm  = IMM_I;
      end
    endcase
  end

  assign ctrl_o    = dec_ctrl;
  assign imm_src_o = dec_imm;

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers around ctrl_decode, plus a
// saturating count of illegal opcodes entering EX.
module control_pipeline
  import riscv_ctrl_pkg::*;
#(
  parameter int EXT_EN   = 1,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op_d,
  input  logic                stall_e,
  input  logic                flush_e,
  output logic [2:0]          imm_src_d,
  output logic                reg_write_e,
  output logic                mem_write_e,
  output logic                alu_src_e,
  output logic                branch_e,
  output logic                jump_e,
  output logic                jalr_e,
  output logic                illegal_e,
  output logic [1:0]          result_src_e,
  output logic [ALU_OP_W-1:0] alu_op_e,
  output logic                reg_write_m,
  output logic                mem_write_m,
  output logic [1:0]          result_src_m,
  output logic                reg_write_w,
  output logic [1:0]          result_src_w,
  output logic [7:0]          illegal_cnt
);

  ctrl_bundle_t dec_ctrl;
  ctrl_bundle_t ex_q, ex_d;
  mem_ctrl_t    mem_q, mem_d;
  logic         wb_rw_q, wb_rw_d;
  logic [1:0]   wb_rs_q, wb_rs_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         capture;

  ctrl_decode #(.EXT_EN(EXT_EN)) u_decode (
    .op_i      (op_d),
    .ctrl_o    (dec_ctrl),
    .imm_src_o (imm_src_d)
  );

  assign capture = !flush_e && !stall_e;

  // Next-state: flush beats stall; a stalled EX sends a bubble downstream.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_rw_d = mem_q.reg_write;
    wb_rs_d = mem_q.result_src;
    cnt_d   = cnt_q;
    if (flush_e) begin
      ex_d = CTRL_BUBBLE;
    end else if (stall_e) begin
      ex_d = ex_q;
    end else begin
      ex_d = dec_ctrl;
    end
    if (stall_e) begin
      mem_d = '0;
    end else begin
      mem_d = '{reg_write: ex_q.reg_write, mem_write: ex_q.mem_write,
                result_src: ex_q.result_src};
    end
    if (capture && dec_ctrl.illegal && (cnt_q != 8'd255)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= CTRL_BUBBLE;
      mem_q   <= '0;
      wb_rw_q <= 1'b0;
      wb_rs_q <= 2'b00;
      cnt_q   <= 8'd0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_rw_q <= wb_rw_d;
      wb_rs_q <= wb_rs_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reg_write_e  = ex_q.reg_write;
  assign mem_write_e  = ex_q.mem_write;
  assign alu_src_e    = ex_q.alu_src;
  assign branch_e     = ex_q.branch;
  assign jump_e       = ex_q.jump;
  assign jalr_e       = ex_q.jalr;
  assign illegal_e    = ex_q.illegal;
  assign result_src_e = ex_q.result_src;
  assign alu_op_e     = ALU_OP_W'(ex_q.alu_op);
  assign reg_write_m  = mem_q.reg_write;
  assign mem_write_m  = mem_q.mem_write;
  assign result_src_m = mem_q.result_src;
  assign reg_write_w  = wb_rw_q;
  assign result_src_w = wb_rs_q;
  assign illegal_cnt  = cnt_q;

endmodule
